uart_rx_ctrl: RTL and testbench

UART receive controller for the RX path: owns the frame state machine, enables and consumes the shared edge/bit counter (`edge_count`/`bit_count`), majority-votes three oversamples per bit, deserializes LSB-first, checks parity and stop, and presents the received byte with a one-cycle valid strobe. It sits between the synchronized serial input and the byte consumer, directly alongside the edge/bit counter it drives.

---
 rtl/uart_rx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, 3-sample majority vote, LSB-first
// deserializer, parity/stop checking and one-cycle result strobes. Drives the
// enable of the neighbouring edge/bit counter and consumes its counts.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_rxc,
  input  logic                  rst_rxc,
  input  logic                  rx_in_rxc,
  input  logic                  par_en_rxc,
  input  logic                  par_typ_rxc,
  input  logic [4:0]            prescale_rxc,
  input  logic [3:0]            edge_count_rxc,
  input  logic [3:0]            bit_count_rxc,
  output logic                  edge_bit_en_rxc,
  output logic [DATA_WIDTH-1:0] p_data_rxc,
  output logic                  data_valid_rxc,
  output logic                  par_err_rxc,
  output logic                  stp_err_rxc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state, state_nxt;
  logic [4:0]            edge_w, half_w;
  logic                  eob, at_s0, at_s1, at_s2;
  logic [2:0]            samp;
  logic                  s2_eff, bit_val;
  logic                  last_data;
  logic                  par_bad, par_bad_eff;
  logic [DATA_WIDTH-1:0] shift_q;

  assign edge_w    = {1'b0, edge_count_rxc};
  assign half_w    = prescale_rxc >> 1;
  assign eob       = (edge_w == prescale_rxc - 5'd1);
  assign at_s0     = (edge_w == half_w - 5'd1);
  assign at_s1     = (edge_w == half_w);
  assign at_s2     = (edge_w == half_w + 5'd1);
  assign last_data = (bit_count_rxc == 4'(DATA_WIDTH));

  // At prescale 4 the third sample edge coincides with end-of-bit, so the
  // vote takes the live line value in place of the not-yet-registered sample.
  assign s2_eff  = at_s2 ? rx_in_rxc : samp[2];
  assign bit_val = (samp[0] & samp[1]) | (samp[0] & s2_eff) | (samp[1] & s2_eff);

  assign par_bad_eff = par_bad & par_en_rxc;

  // State register; counter enable registered from the next state.
  always_ff @(posedge clk_rxc or posedge rst_rxc) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of block ordering.
    if (rst_rxc) begin
      state           <= ST_IDLE;
      edge_bit_en_rxc <= 1'b0;
    end else begin
      state           <= state_nxt;
      edge_bit_en_rxc <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rx_in_rxc) state_nxt = ST_START;
      ST_START:  if (eob) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (eob && last_data) state_nxt = par_en_rxc ? ST_PARITY : ST_STOP;
      ST_PARITY: if (eob) state_nxt = ST_STOP;
      ST_STOP:   if (eob) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture the three oversamples around the bit centre.
  always_ff @(posedge clk_rxc or posedge rst_rxc) begin
    if (rst_rxc) begin
      samp <= '0;
    end else begin
      if (at_s0) samp[0] <= rx_in_rxc;
      if (at_s1) samp[1] <= rx_in_rxc;
      if (at_s2) samp[2] <= rx_in_rxc;
    end
  end

  // Deserialize data bits LSB-first and record the parity verdict.
  always_ff @(posedge clk_rxc or posedge rst_rxc) begin
    // NOTE: the shift register is a plain register, so it is reset along with
    // the control state; a stale byte can never leak into p_data.
    if (rst_rxc) begin
      shift_q <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   par_bad <= 1'b0;
        ST_DATA:   if (eob) shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
        ST_PARITY: if (eob) par_bad <= bit_val ^ (^shift_q) ^ par_typ_rxc;
        default:   ;
      endcase
    end
  end

  // Result strobes and byte hold register, updated at the end of the stop bit.
  always_ff @(posedge clk_rxc or posedge rst_rxc) begin
    if (rst_rxc) begin
      p_data_rxc     <= '0;
      data_valid_rxc <= 1'b0;
      par_err_rxc    <= 1'b0;
      stp_err_rxc    <= 1'b0;
    end else begin
      data_valid_rxc <= 1'b0;
      par_err_rxc    <= 1'b0;
      stp_err_rxc    <= 1'b0;
      if (state == ST_STOP && eob) begin
        data_valid_rxc <= bit_val & ~par_bad_eff;
        par_err_rxc    <= par_bad_eff;
        stp_err_rxc    <= ~bit_val;
        if (bit_val && !par_bad_eff) p_data_rxc <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a frame-level reference model predicts
// every output in every cycle of a line waveform; directed scenarios add
// explicit cycle-accurate checks.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic          clk_rxc = 1'b0;
  logic          rst_rxc;
  logic          rx_in_rxc;
  logic          par_en_rxc;
  logic          par_typ_rxc;
  logic [4:0]    prescale_rxc;
  logic [3:0]    edge_count_rxc;
  logic [3:0]    bit_count_rxc;
  logic          edge_bit_en_rxc;
  logic [DW-1:0] p_data_rxc;
  logic          data_valid_rxc;
  logic          par_err_rxc;
  logic          stp_err_rxc;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          line[$];
  logic [11:0] obs[$];
  logic [7:0]  model_pdata = '0;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_rxc         (clk_rxc),
    .rst_rxc         (rst_rxc),
    .rx_in_rxc       (rx_in_rxc),
    .par_en_rxc      (par_en_rxc),
    .par_typ_rxc     (par_typ_rxc),
    .prescale_rxc    (prescale_rxc),
    .edge_count_rxc  (edge_count_rxc),
    .bit_count_rxc   (bit_count_rxc),
    .edge_bit_en_rxc (edge_bit_en_rxc),
    .p_data_rxc      (p_data_rxc),
    .data_valid_rxc  (data_valid_rxc),
    .par_err_rxc     (par_err_rxc),
    .stp_err_rxc     (stp_err_rxc)
  );

  always #5 clk_rxc = ~clk_rxc;

  // Neighbouring edge/bit counter, as seen by the controller.
  always @(posedge clk_rxc or posedge rst_rxc) begin
    if (rst_rxc || !edge_bit_en_rxc) begin
      edge_count_rxc <= '0;
      bit_count_rxc  <= '0;
    end else if (edge_count_rxc == 4'(prescale_rxc - 5'd1)) begin
      edge_count_rxc <= '0;
      bit_count_rxc  <= bit_count_rxc + 4'd1;
    end else begin
      edge_count_rxc <= edge_count_rxc + 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {edge_bit_en_rxc, data_valid_rxc, par_err_rxc, stp_err_rxc, p_data_rxc};
  endfunction

  function automatic int n_bits();
    return DW + 2 + (par_en_rxc ? 1 : 0);
  endfunction

  // Append one frame: cycle 0 low, then bit k held for cycles 1+P*k..P*(k+1).
  task automatic add_frame(input logic [7:0] d, input logic pbit, input logic stop);
    int p = int'(prescale_rxc);
    int n = n_bits();
    bit fb[16];
    fb[0] = 1'b0;
    for (int i = 0; i < DW; i++) fb[1+i] = d[i];
    if (par_en_rxc) fb[DW+1] = pbit;
    fb[n-1] = stop;
    line.push_back(1'b0);
    for (int c = 1; c <= p * n; c++) line.push_back(fb[(c-1)/p]);
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) line.push_back(1'b1);
  endtask

  function automatic bit line_at(input int i);
    return (i < line.size()) ? line[i] : 1'b1;
  endfunction

  // Majority of the three centre samples of bit k of a frame starting at t0.
  function automatic bit vote(input int t0, input int k);
    int p = int'(prescale_rxc);
    int b = t0 + 1 + p * k + p / 2 - 1;
    bit a0 = line_at(b);
    bit a1 = line_at(b + 1);
    bit a2 = line_at(b + 2);
    return (a0 & a1) | (a0 & a2) | (a1 & a2);
  endfunction

  function automatic int count_field(input int b);
    int c = 0;
    foreach (obs[i]) if (obs[i][b]) c++;
    return c;
  endfunction

  // Predict every cycle of the current line waveform, drive it and compare.
  task automatic run_stream(input string name);
    int p, n, l, t, t0, s;
    logic e_en[], e_v[], e_p[], e_s[], ld[];
    logic [7:0] ldv[];
    logic [7:0] cur, d;
    logic [11:0] got, exp;
    bit pbad, stop;
    add_idle(200);
    p = int'(prescale_rxc);
    n = n_bits();
    l = line.size();
    e_en = new[l]; e_v = new[l]; e_p = new[l]; e_s = new[l]; ld = new[l]; ldv = new[l];
    for (int i = 0; i < l; i++) begin
      e_en[i] = 0; e_v[i] = 0; e_p[i] = 0; e_s[i] = 0; ld[i] = 0; ldv[i] = '0;
    end
    t = 0;
    while (t < l) begin
      if (line[t]) begin
        t++;
        continue;
      end
      t0 = t;
      if (vote(t0, 0)) begin
        for (int c = t0 + 1; c <= t0 + p && c < l; c++) e_en[c] = 1;
        t = t0 + p + 1;
        continue;
      end
      d = '0;
      for (int i = 0; i < DW; i++) d[i] = vote(t0, 1 + i);
      pbad = par_en_rxc ? (vote(t0, DW + 1) ^ (^d) ^ par_typ_rxc) : 1'b0;
      stop = vote(t0, n - 1);
      for (int c = t0 + 1; c <= t0 + p * n && c < l; c++) e_en[c] = 1;
      s = t0 + p * n + 1;
      if (s < l) begin
        e_v[s] = stop & ~pbad;
        e_p[s] = pbad;
        e_s[s] = ~stop;
        ld[s]  = stop & ~pbad;
        ldv[s] = d;
      end
      t = s;
    end
    cur = model_pdata;
    obs.delete();
    for (int i = 0; i < l; i++) begin
      if (ld[i]) cur = ldv[i];
      exp = {e_en[i], e_v[i], e_p[i], e_s[i], cur};
      @(posedge clk_rxc);
      #1;
      got = outs();
      obs.push_back(got);
      check($sformatf("%s_cyc%0d", name, i), 32'(got), 32'(exp));
      rx_in_rxc = line[i];
    end
    model_pdata = cur;
    line.delete();
  endtask

  initial begin
    int   base, cnt, nf, g, k, j, idx;
    logic [7:0] d;
    logic pbit, stop;

    rst_rxc      = 1'b1;
    rx_in_rxc    = 1'b1;
    par_en_rxc   = 1'b0;
    par_typ_rxc  = 1'b0;
    prescale_rxc = 5'd8;
    repeat (3) @(posedge clk_rxc);
    #1;
    check("reset_outputs", 32'(outs()), 32'h0);
    rst_rxc = 1'b0;
    repeat (2) @(posedge clk_rxc);
    #1;

    // 8N1, P=8, 0xA5: strobe in cycle 81 only.
    add_frame(8'hA5, 1'b0, 1'b1);
    run_stream("a5");
    check("a5_valid_c80", 32'(obs[80][10]), 32'd0);
    check("a5_valid_c81", 32'(obs[81][10]), 32'd1);
    check("a5_valid_c82", 32'(obs[82][10]), 32'd0);
    check("a5_pdata", 32'(obs[81][7:0]), 32'hA5);
    check("a5_nvalid", count_field(10), 1);
    check("a5_nerr", count_field(9) + count_field(8), 0);
    check("a5_en_c80", 32'(obs[80][11]), 32'd1);
    check("a5_en_c81", 32'(obs[81][11]), 32'd0);

    // 8E1, P=16, 0x3C with parity 0: good frame, strobe at 177.
    prescale_rxc = 5'd16;
    par_en_rxc   = 1'b1;
    add_frame(8'h3C, 1'b0, 1'b1);
    run_stream("e1");
    check("e1_valid_c177", 32'(obs[177][10]), 32'd1);
    check("e1_valid_c176", 32'(obs[176][10]), 32'd0);
    check("e1_pdata", 32'(obs[177][7:0]), 32'h3C);

    // Odd parity selected, parity bit 0: parity error, p_data held.
    par_typ_rxc = 1'b1;
    add_frame(8'h3C, 1'b0, 1'b1);
    run_stream("o1");
    check("o1_perr_c177", 32'(obs[177][9]), 32'd1);
    check("o1_perr_c178", 32'(obs[178][9]), 32'd0);
    check("o1_nvalid", count_field(10), 0);
    check("o1_pdata", 32'(obs[177][7:0]), 32'h3C);

    // Stop bit low, P=8, 0x55: stop error at 81.
    prescale_rxc = 5'd8;
    par_en_rxc   = 1'b0;
    par_typ_rxc  = 1'b0;
    add_frame(8'h55, 1'b0, 1'b0);
    run_stream("stp");
    check("stp_serr_c81", 32'(obs[81][8]), 32'd1);
    check("stp_nvalid", count_field(10), 0);
    check("stp_pdata", 32'(obs[81][7:0]), 32'h3C);

    // Start glitch of two cycles: back to IDLE at cycle 9, no strobes.
    line.push_back(1'b0);
    line.push_back(1'b0);
    run_stream("gl");
    check("gl_en_c8", 32'(obs[8][11]), 32'd1);
    check("gl_en_c9", 32'(obs[9][11]), 32'd0);
    check("gl_nstrobe", count_field(10) + count_field(9) + count_field(8), 0);

    // One-cycle low on the centre sample of data bit 3 is outvoted.
    base = line.size();
    add_frame(8'hFF, 1'b0, 1'b1);
    line[base + 37] = 1'b0;
    run_stream("ff");
    check("ff_valid_c81", 32'(obs[81][10]), 32'd1);
    check("ff_pdata", 32'(obs[81][7:0]), 32'hFF);

    // Back-to-back frames with no idle gap.
    add_frame(8'h01, 1'b0, 1'b1);
    add_frame(8'h80, 1'b0, 1'b1);
    run_stream("b2b");
    check("b2b_valid_c81", 32'(obs[81][10]), 32'd1);
    check("b2b_pdata0", 32'(obs[81][7:0]), 32'h01);
    check("b2b_valid_c162", 32'(obs[162][10]), 32'd1);
    check("b2b_pdata1", 32'(obs[162][7:0]), 32'h80);
    check("b2b_nvalid", count_field(10), 2);

    // Reset mid-frame, then a long idle line.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_rxc);
      #1;
      rx_in_rxc = (i < 9) ? 1'b0 : 1'b1;
    end
    check("pre_rst_en", 32'(edge_bit_en_rxc), 32'd1);
    #2;
    rst_rxc = 1'b1;
    #1;
    check("mid_rst_outputs", 32'(outs()), 32'h0);
    repeat (3) @(posedge clk_rxc);
    #1;
    rst_rxc     = 1'b0;
    model_pdata = '0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_rxc);
      #1;
      if (edge_bit_en_rxc) cnt++;
    end
    check("idle_en_count", cnt, 0);
    check("idle_pdata", 32'(p_data_rxc), 32'h0);

    // Randomized streams checked cycle by cycle against the frame model.
    for (int s = 0; s < 15; s++) begin
      case ($urandom_range(0, 2))
        0:       prescale_rxc = 5'd4;
        1:       prescale_rxc = 5'd8;
        default: prescale_rxc = 5'd16;
      endcase
      par_en_rxc  = 1'($urandom_range(0, 1));
      par_typ_rxc = 1'($urandom_range(0, 1));
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 5) == 0) begin
          g = $urandom_range(1, int'(prescale_rxc) / 2);
          for (int q = 0; q < g; q++) line.push_back(1'b0);
          add_idle(int'(prescale_rxc));
        end
        d    = 8'($urandom);
        pbit = (^d) ^ par_typ_rxc;
        if ($urandom_range(0, 3) == 0) pbit = ~pbit;
        stop = ($urandom_range(0, 4) != 0);
        base = line.size();
        add_frame(d, pbit, stop);
        if ($urandom_range(0, 3) == 0) begin
          k   = $urandom_range(1, n_bits() - 1);
          j   = $urandom_range(0, 2);
          idx = base + 1 + int'(prescale_rxc) * k + int'(prescale_rxc) / 2 - 1 + j;
          line[idx] = ~line[idx];
        end
        add_idle($urandom_range(0, 3));
      end
      run_stream($sformatf("rnd%0d", s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
